// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed-priority
// arbitration, feeding a single registered output stage (data + source index).
module stream_mux_rr #(
    parameter int WIDTH     = 4,
    parameter int N         = 4,
    parameter int PRIO_MODE = 0,
    localparam int SW       = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SW-1:0]        out_sel
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_sel;
    logic [SW-1:0]    r_ptr;

    logic             w_free;
    logic             w_found;
    logic [SW-1:0]    w_base;
    logic [SW-1:0]    w_gnt;
    logic [SW-1:0]    w_cand;
    logic [SW:0]      w_sum;
    logic [N-1:0]     w_ready;
    logic [WIDTH-1:0] w_data;

    assign w_free = !r_out_valid || out_ready;
    assign w_base = (PRIO_MODE != 0) ? '0 : r_ptr;

    // Scan from w_base upward, wrapping at N (not at 2**SW) for odd channel counts.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, w_base} + (SW+1)'(k);
            if (w_sum >= (SW+1)'(N)) begin
                w_sum = w_sum - (SW+1)'(N);
            end
            w_cand = w_sum[SW-1:0];
            if (!w_found && in_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_free && w_found && !rst) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    // One-hot select so data of non-granted channels never reaches the register.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_ready[i]) begin
                w_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_free) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_data <= w_data;
                r_out_sel  <= w_gnt;
                if (PRIO_MODE == 0) begin
                    r_ptr <= (w_gnt == SW'(N-1)) ? '0 : w_gnt + SW'(1);
                end
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: round-robin N=4, round-robin N=3 and fixed-priority N=4
// instances run in lockstep against a per-instance reference model.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic [3:0] rdy4, rdyf;
    logic [2:0] rdy3;
    logic       ov4, ov3, ovf;
    logic [3:0] od4, od3, odf;
    logic [1:0] os4, os3, osf;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(4), .N(4), .PRIO_MODE(0)) u_rr4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_sel(os4));

    stream_mux_rr #(.WIDTH(4), .N(3), .PRIO_MODE(0)) u_rr3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2:0]), .in_ready(rdy3), .in_data(in_data[11:0]),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .out_sel(os3));

    stream_mux_rr #(.WIDTH(4), .N(4), .PRIO_MODE(1)) u_fp4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyf), .in_data(in_data),
        .out_valid(ovf), .out_ready(out_ready), .out_data(odf), .out_sel(osf));

    // Reference model state: instance 0 = rr4, 1 = rr3, 2 = fixed priority
    int         nn[3]   = '{4, 3, 4};
    int         mode[3] = '{0, 0, 1};
    int         m_p[3];
    logic       m_v[3];
    logic [3:0] m_d[3];
    int         m_s[3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] v;
        logic       rdy;
        logic       ev;
        int         es;
        logic [3:0] ed;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Requesting channel closest to the search origin, walking upward modulo n.
    function automatic int pick(input int id, input logic [3:0] v);
        int c;
        for (int k = 0; k < nn[id]; k++) begin
            c = (mode[id] == 1) ? k : (m_p[id] + k) % nn[id];
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] a_rdy(input int id);
        case (id)
            0:       return rdy4;
            1:       return {1'b0, rdy3};
            default: return rdyf;
        endcase
    endfunction

    function automatic logic a_ov(input int id);
        case (id)
            0:       return ov4;
            1:       return ov3;
            default: return ovf;
        endcase
    endfunction

    function automatic logic [3:0] a_od(input int id);
        case (id)
            0:       return od4;
            1:       return od3;
            default: return odf;
        endcase
    endfunction

    function automatic logic [1:0] a_os(input int id);
        case (id)
            0:       return os4;
            1:       return os3;
            default: return osf;
        endcase
    endfunction

    task automatic model_clear();
        for (int id = 0; id < 3; id++) begin
            m_p[id] = 0;
            m_v[id] = 1'b0;
            m_d[id] = '0;
            m_s[id] = 0;
        end
    endtask

    task automatic step();
        int   g[3];
        logic fr[3];
        #1;
        for (int id = 0; id < 3; id++) begin
            g[id]  = pick(id, in_valid);
            fr[id] = !m_v[id] || out_ready;
            chk($sformatf("in_ready[%0d]", id), a_rdy(id),
                (fr[id] && g[id] >= 0) ? (32'd1 << g[id]) : 32'd0);
        end
        @(posedge clk);
        for (int id = 0; id < 3; id++) begin
            if (fr[id]) begin
                if (g[id] >= 0) begin
                    m_v[id] = 1'b1;
                    m_d[id] = in_data[g[id]*4 +: 4];
                    m_s[id] = g[id];
                    if (mode[id] == 0) m_p[id] = (g[id] + 1) % nn[id];
                end else begin
                    m_v[id] = 1'b0;
                end
            end
        end
        #1;
        for (int id = 0; id < 3; id++) begin
            chk($sformatf("out_valid[%0d]", id), a_ov(id), m_v[id]);
            chk($sformatf("out_data[%0d]", id), a_od(id), m_d[id]);
            chk($sformatf("out_sel[%0d]", id), a_os(id), m_s[id]);
        end
    endtask

    task automatic reset_zero_check(input string nm);
        for (int id = 0; id < 3; id++) begin
            chk($sformatf("%s_ov[%0d]", nm, id), a_ov(id), 0);
            chk($sformatf("%s_od[%0d]", nm, id), a_od(id), 0);
            chk($sformatf("%s_os[%0d]", nm, id), a_os(id), 0);
            chk($sformatf("%s_rdy[%0d]", nm, id), a_rdy(id), 0);
        end
    endtask

    task automatic do_reset();
        in_valid = 4'b1111;
        #2 rst = 1'b1;
        model_clear();
        #1 reset_zero_check("rst_async");
        @(posedge clk);
        #1 reset_zero_check("rst_hold");
        rst = 1'b0;
        in_valid = 4'b0000;
    endtask

    int exp3[4] = '{0, 2, 0, 2};

    initial begin
        tbl[0] = '{4'b1111, 1'b1, 1'b1, 0, 4'hA};
        tbl[1] = '{4'b1111, 1'b1, 1'b1, 1, 4'hB};
        tbl[2] = '{4'b1111, 1'b1, 1'b1, 2, 4'hC};
        tbl[3] = '{4'b1111, 1'b1, 1'b1, 3, 4'hD};
        tbl[4] = '{4'b1111, 1'b1, 1'b1, 0, 4'hA};
        tbl[5] = '{4'b0100, 1'b1, 1'b1, 2, 4'hC};
        tbl[6] = '{4'b0000, 1'b1, 1'b0, 2, 4'hC};
        tbl[7] = '{4'b1001, 1'b1, 1'b1, 3, 4'hD};
        tbl[8] = '{4'b1001, 1'b1, 1'b1, 0, 4'hA};

        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 16'hDCBA;
        out_ready = 1'b1;
        model_clear();
        #3 reset_zero_check("rst_init");
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 4'b0000;
        step();
        step();

        // Round-robin fairness on the 4-channel instance
        for (int i = 0; i < 9; i++) begin
            in_valid  = tbl[i].v;
            out_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_ov", i), ov4, tbl[i].ev);
            chk($sformatf("tbl%0d_os", i), os4, tbl[i].es);
            chk($sformatf("tbl%0d_od", i), od4, tbl[i].ed);
        end

        // Backpressure: word from channel 1 holds while out_ready is low
        in_data   = 16'hDC7A;
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        step();
        chk("bp_first_od", od4, 4'h7);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ov", ov4, 1);
            chk("bp_od", od4, 4'h7);
            chk("bp_os", os4, 1);
            chk("bp_rdy", rdy4, 0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", rdy4, 4'b0010);
        step();
        chk("bp_release_os", os4, 1);

        // Reset while a word is held
        do_reset();
        step();
        step();
        chk("post_rst_idle_ov", ov4, 0);

        // N=3 skip/wrap, fixed priority lowest index in parallel
        in_data  = 16'hDCBA;
        in_valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("n3_skip%0d", i), os3, exp3[i]);
            chk($sformatf("fp_0101_%0d", i), osf, 0);
        end
        in_valid = 4'b0010;
        step();
        chk("n3_single", os3, 1);
        in_valid = 4'b0111;
        step();
        chk("n3_ptr_after_1", os3, 2);

        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("fp_1010_%0d", i), osf, 1);
        end
        in_valid = 4'b1000;
        step();
        chk("fp_ch3_after_drop", osf, 3);

        // X on an idle channel must not leak
        in_data  = {4'bxxxx, 12'h321};
        in_valid = 4'b0111;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("x_od_known", $isunknown(od4), 0);
            chk("x_os_not3", os4 == 2'd3, 0);
        end
        in_data = 16'hDCBA;

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_valid  = 4'($urandom);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel stream multiplexer with valid/ready handshakes and a registered output. It selects one word per cycle from up to N requesting input channels, by round-robin or fixed priority, and presents the word with its source channel index. It supersedes the plain combinational 4:1 selector wherever producers and the consumer need flow control and fair sharing of one downstream path.

## Interface
- WIDTH, 4, data width per channel in bits (>= 1)
- N, 4, number of input channels (>= 2; need not be a power of two)
- PRIO_MODE, 0, 0 = round-robin arbitration, 1 = fixed priority (lowest index wins)
- SW, $clog2(N), width of the channel index (localparam, derived)

- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  N  per-channel request; bit i belongs to channel i
- in_ready  output  N  per-channel accept; at most one bit set
- in_data  input  N*WIDTH  flattened channel data; channel i is in_data[i*WIDTH +: WIDTH]
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts output word
- out_data  output  WIDTH  registered selected word
- out_sel  output  SW  registered index of the channel that supplied out_data

## Operation
- Single output register (out_valid, out_data, out_sel); the register is "free" when !out_valid || out_ready.
- Free and at least one in_valid set: exactly one channel g is granted; in_ready[g] = 1, all other in_ready = 0; on the clock edge out_data <= channel g data, out_sel <= g, out_valid <= 1.
- Free and no in_valid: all in_ready = 0; out_valid <= 0 on the edge.
- Not free (out_valid && !out_ready): all in_ready = 0; out_valid, out_data and out_sel hold unchanged.
- in_ready[i] is combinational from in_valid, out_valid, out_ready and arbiter state; no in_valid bit depends on in_ready.
- A transfer on channel i occurs on a cycle where in_valid[i] && in_ready[i]; a transfer on the output occurs when out_valid && out_ready.
- Round-robin (PRIO_MODE = 0): pointer p (SW bits, range 0..N-1). Search starts at channel p, ascends, wraps N-1 -> 0; first requesting channel wins. After an input transfer on g, p <= (g == N-1) ? 0 : g+1. Without a transfer, p holds.
- Fixed priority (PRIO_MODE = 1): lowest-indexed requesting channel wins; p is unused and stays 0.
- Grant decision uses only the current in_valid; a channel that drops in_valid before acceptance loses nothing and holds no grant.

## Timing
- Reset (async assert, any cycle): out_valid = 0, out_data = 0, out_sel = 0, p = 0; in_ready = 0 while rst high. A word held in the output register at reset is discarded.
- Latency: input transfer in cycle t -> out_valid and data visible after edge t, i.e. in cycle t+1.
- Throughput: one word per cycle when out_ready is held high; no bubbles between back-to-back words, from the same or different channels.
- Simultaneous output drain and input accept in one cycle is required (register free because out_ready = 1).
- Backpressure: while out_valid && !out_ready, out_data and out_sel are stable cycle to cycle.
- Non-power-of-two N: pointer wraps from N-1 to 0; values >= N never occur; out_sel < N always.
- X on in_data of a non-granted channel must not propagate to out_data.

## Test plan
- Reset: assert rst mid-stream with out_valid = 1 -> out_valid, out_data, out_sel, all in_ready 0 immediately; after release with no requests, out_valid stays 0.
- Round-robin fairness, N=4, WIDTH=4, in_valid = 4'b1111, channel data a,b,c,d, out_ready = 1 -> out_sel sequence 0,1,2,3,0,..., out_data a,b,c,d,a, one word per cycle.
- Pointer skip/wrap, N=3: in_valid = 3'b101 constant, out_ready = 1 -> grants 0,2,0,2; then in_valid = 3'b010 only -> grant 1, next p = 2.
- Backpressure: in_valid[1] = 1 with data 7, out_ready = 0 for 3 cycles after first word -> out_valid = 1, out_data = 7, out_sel = 1 stable, in_ready = 0 throughout; out_ready = 1 -> next word accepted same cycle.
- Fixed priority, PRIO_MODE = 1, in_valid = 4'b1010 persistent -> out_sel always 1; channel 3 granted only when in_valid[1] drops.
- X isolation: channel 3 data = 'x, in_valid = 4'b0111 round-robin -> out_data never X, out_sel never 3.
